mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 15 +
 rtl/MUX4TO1.sv | 23 ++
 rtl/rr_pick4.sv | 32 +++
 rtl/mux4_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
//   NUM_REQ : number of requesters sharing the datapath
//   CNT_W   : width of the per-grant beat counter
//   state_t : arbiter FSM encoding (IDLE = 0, GRANT = 1)
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/MUX4TO1.sv
// Single-bit 4:1 multiplexer cell.
//   i0..i3 : data inputs
//   s      : select, 2 bits
//   y      : selected input
module MUX4TO1 (
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic [1:0] s,
  output logic       y
);

  always_comb begin
    unique case (s)
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      default: y = i3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requesters.
//   req : request vector
//   ptr : highest-priority requester for this pick
//   idx : first set req bit at or after ptr, wrapping 3 -> 0
//   any : at least one request is set
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] off;

  // Rotate so that bit 0 of req_rot is the requester at ptr; a plain
  // lowest-bit priority encode then gives the offset from ptr.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: 4];

  always_comb begin
    off = 2'd3;
    if      (req_rot[0]) off = 2'd0;
    else if (req_rot[1]) off = 2'd1;
    else if (req_rot[2]) off = 2'd2;
  end

  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 datapath.
// A requester is granted for up to MAX_BEATS beats or until it drops its
// request; every grant is followed by one IDLE bubble cycle.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req[3:0]       : per-requester request, held while data is available
//   d0..d3         : requester data, DATA_W bits each
//   ack[3:0]       : per-requester beat-accepted strobe
//   sel[1:0]       : registered datapath select
//   y              : d[sel]
//   y_valid        : beat on y is valid
//   y_ready        : downstream accepts the beat
//   busy           : arbiter is in GRANT
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        ack,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic             granted;
  logic             req_sel;
  logic             beat;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign granted   = (state == GRANT);
  assign req_sel   = req[sel];
  assign beat      = granted & req_sel & y_ready;
  assign count_nxt = count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            sel   <= pick_idx;
            count <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req_sel) begin
            ptr   <= sel + 2'd1;
            state <= IDLE;
          end else if (y_ready) begin
            count <= count_nxt;
            if (count_nxt == LAST_BEAT) begin
              ptr   <= sel + 2'd1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the granted requester can see its ack; reset forces state to
  // IDLE asynchronously, which silences ack/y_valid/busy in the same cycle.
  always_comb begin
    ack = 4'b0000;
    if (beat) ack[sel] = 1'b1;
  end

  assign y_valid = granted & req_sel;
  assign busy    = granted;

  for (genvar b = 0; b < DATA_W; b++) begin : g_mux
    MUX4TO1 u_mux (
      .i0 (d0[b]),
      .i1 (d1[b]),
      .i2 (d2[b]),
      .i3 (d3[b]),
      .s  (sel),
      .y  (y[b])
    );
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [7:0] d0 = 8'h11, d1 = 8'h22, d2 = 8'hA5, d3 = 8'h3C;
  logic [3:0] ack;
  logic [1:0] sel;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready = 1'b1;
  logic       busy;

  int ncmp = 0;
  int nfail = 0;

  mux4_rr_arbiter #(.DATA_W(8), .MAX_BEATS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .ack     (ack),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic [7:0] y;
    logic       vld;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge, sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic rdy);
    @(negedge clk);
    req = r;
    y_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1111;
    y_ready = 1'b1;
    #1;
    check("rst_ack", ack, 0);
    check("rst_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_y", y, d0);
    repeat (2) @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
  endtask

  initial begin
    int grant_sel[$];
    int grant_beats[$];
    int gaps[$];
    int gap_cnt;
    logic prev_busy;

    // Single-requester burst, drop of a request, pointer rotation.
    vecs[0]  = '{4'b0100, 1'b1, 2'd0, 8'h11, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0100, 1'b1, 2'd2, 8'hA5, 1'b1, 4'b0100, 1'b1};
    vecs[2]  = '{4'b0100, 1'b1, 2'd2, 8'hA5, 1'b1, 4'b0100, 1'b1};
    vecs[3]  = '{4'b0100, 1'b1, 2'd2, 8'hA5, 1'b1, 4'b0100, 1'b1};
    vecs[4]  = '{4'b0100, 1'b1, 2'd2, 8'hA5, 1'b1, 4'b0100, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 2'd2, 8'hA5, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{4'b1111, 1'b1, 2'd2, 8'hA5, 1'b0, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1111, 1'b0, 2'd3, 8'h3C, 1'b1, 4'b0000, 1'b1};
    vecs[8]  = '{4'b1111, 1'b1, 2'd3, 8'h3C, 1'b1, 4'b1000, 1'b1};
    vecs[9]  = '{4'b0111, 1'b1, 2'd3, 8'h3C, 1'b0, 4'b0000, 1'b1};
    vecs[10] = '{4'b0110, 1'b1, 2'd3, 8'h3C, 1'b0, 4'b0000, 1'b0};
    vecs[11] = '{4'b0110, 1'b1, 2'd1, 8'h22, 1'b1, 4'b0010, 1'b1};
    vecs[12] = '{4'b0000, 1'b1, 2'd1, 8'h22, 1'b0, 4'b0000, 1'b1};
    vecs[13] = '{4'b0000, 1'b1, 2'd1, 8'h22, 1'b0, 4'b0000, 1'b0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].req, vecs[i].rdy);
      check($sformatf("v%0d_sel", i), sel, vecs[i].sel);
      check($sformatf("v%0d_y", i), y, vecs[i].y);
      check($sformatf("v%0d_valid", i), y_valid, vecs[i].vld);
      check($sformatf("v%0d_ack", i), ack, vecs[i].ack);
      check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
    end

    // All four requesting: strict rotation, 4 beats each, one bubble.
    do_reset();
    prev_busy = 1'b0;
    gap_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step(4'b1111, 1'b1);
      if (busy && !prev_busy) begin
        grant_sel.push_back(int'(sel));
        grant_beats.push_back(0);
        if (grant_sel.size() > 1) gaps.push_back(gap_cnt);
        gap_cnt = 0;
      end
      if (!busy) gap_cnt++;
      if (busy && ack != 4'b0000) grant_beats[grant_beats.size()-1]++;
      prev_busy = busy;
    end
    check("rot_count_ge5", int'(grant_sel.size() >= 5), 1);
    if (grant_sel.size() >= 5) begin
      check("rot_g0", grant_sel[0], 0);
      check("rot_g1", grant_sel[1], 1);
      check("rot_g2", grant_sel[2], 2);
      check("rot_g3", grant_sel[3], 3);
      check("rot_g4", grant_sel[4], 0);
      for (int g = 0; g < 4; g++) begin
        check($sformatf("rot_beats%0d", g), grant_beats[g], 4);
        check($sformatf("rot_gap%0d", g), gaps[g], 1);
      end
    end

    // Back-pressure on requester 1 holds sel and the beat count.
    do_reset();
    step(4'b0010, 1'b1);
    check("bp_idle_busy", busy, 0);
    step(4'b0010, 1'b1);
    check("bp_first_ack", ack, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      step(4'b0010, 1'b0);
      check($sformatf("bp_hold%0d_valid", c), y_valid, 1);
      check($sformatf("bp_hold%0d_ack", c), ack, 0);
      check($sformatf("bp_hold%0d_sel", c), sel, 1);
      check($sformatf("bp_hold%0d_busy", c), busy, 1);
    end
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b1);
      check($sformatf("bp_resume%0d_ack", c), ack, 4'b0010);
    end
    step(4'b0010, 1'b1);
    check("bp_end_busy", busy, 0);

    // Asynchronous reset in the middle of a grant on requester 2.
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    check("ar_pre_busy", busy, 1);
    check("ar_pre_sel", sel, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_valid", y_valid, 0);
    check("ar_ack", ack, 0);
    check("ar_sel", sel, 0);
    check("ar_y", y, d0);
    @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    check("ar_after_idle", busy, 0);
    step(4'b1111, 1'b1);
    check("ar_after_sel", sel, 0);
    check("ar_after_busy", busy, 1);

    // With ptr = 1, req = 1001 grants 3 before 0.
    do_reset();
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    check("p1_g0_sel", sel, 0);
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b1);
    check("p1_idle_busy", busy, 0);
    step(4'b1001, 1'b1);
    check("p1_sel", sel, 3);
    check("p1_y", y, d3);
    check("p1_ack", ack, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
